sram_request_queue: RTL and testbench

Upstream front-end for `sram_controller`. Accepts CPU word requests over a valid/ready handshake, buffers them in an in-order FIFO, and replays each one to the controller over its `access_n`/`busy_n` handshake. Read data goes back to the CPU as a one-cycle response pulse. Writes are posted: they are accepted and complete without a response.

---
 rtl/sram_pkg.sv | 27 ++
 rtl/sram_request_queue_if.sv | 39 +++
 rtl/sram_req_fifo.sv | 72 +++++++
 rtl/sram_request_queue.sv | 143 ++++++++++++++
 tb/tb_sram_request_queue.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM request queue: FSM state encoding,
// default bus widths and the width of one buffered request.
package sram_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_ISSUE     = ST_ISSUE,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE
  } state_e;

  // One FIFO entry is {we, addr, wdata}.
  function automatic int entry_w(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

  localparam int DEF_ENTRY_W = entry_w(DEF_ADDR_W, DEF_DATA_W);

endpackage

// File: rtl/sram_request_queue_if.sv
// CPU request/response channel plus the sram_controller access channel,
// bundled so the queue and its environment connect through one port.
interface sram_request_queue_if #(
  parameter int ADDR_W = sram_pkg::DEF_ADDR_W,
  parameter int DATA_W = sram_pkg::DEF_DATA_W
);
  // Request handshake: a transfer happens on every rising edge where
  // req_valid and req_ready are both 1; the requester holds req_we/req_addr/
  // req_wdata stable while req_valid is 1, and req_ready never depends on
  // req_valid. rsp_valid and req_err are single-cycle pulses with no backpressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              req_err;

  logic              access_n;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              busy_n;
  logic [DATA_W-1:0] read_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, busy_n, read_data,
    output req_ready, rsp_valid, rsp_rdata, req_err,
           access_n, we, address, write_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, busy_n, read_data,
    input  req_ready, rsp_valid, rsp_rdata, req_err,
           access_n, we, address, write_data
  );

endinterface

// File: rtl/sram_req_fifo.sv
// Synchronous in-order FIFO; power-of-two DEPTH so pointers wrap naturally.
// Push when full and pop when empty are ignored.
module sram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_request_queue.sv
// CPU-side request queue in front of sram_controller: buffers requests and
// replays them one at a time. Optional macro SRAM_REQ_ALIGN_CHECK_EN drops
// misaligned requests and pulses req_err instead.
module sram_request_queue
  import sram_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sram_request_queue_if.slave    bus,
  output state_e                 dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);

  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               head_we;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  state_e             state_q, state_d;
  logic               access_n_q, access_n_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  write_data_q, write_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  sram_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count)
  );

  assign bus.req_ready = !fifo_full;
  assign accept        = bus.req_valid && !fifo_full;
  assign fifo_wdata    = {bus.req_we, bus.req_addr, bus.req_wdata};
  assign head_we       = fifo_rdata[ENTRY_W-1];
  assign head_addr     = fifo_rdata[ADDR_W+DATA_W-1 -: ADDR_W];
  assign head_wdata    = fifo_rdata[DATA_W-1:0];
  // The head stays valid through ISSUE and leaves at the end of it.
  assign fifo_pop      = (state_q == S_ISSUE);

`ifdef SRAM_REQ_ALIGN_CHECK_EN
  logic misaligned;
  logic req_err_q, req_err_d;

  assign misaligned  = (bus.req_addr[1:0] != 2'b00);
  assign fifo_push   = accept && !misaligned;
  assign req_err_d   = accept && misaligned;
  assign bus.req_err = req_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) req_err_q <= 1'b0;
    else        req_err_q <= req_err_d;
  end
`else
  assign fifo_push   = accept;
  assign bus.req_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    access_n_d   = 1'b1;
    we_d         = we_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && bus.busy_n) begin
          state_d      = S_ISSUE;
          access_n_d   = 1'b0;
          we_d         = head_we;
          address_d    = head_addr;
          write_data_d = head_wdata;
        end
      end
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.busy_n) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (bus.busy_n) begin
          state_d = S_IDLE;
          // we_q still holds the finished transaction's direction.
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus.read_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      access_n_q   <= 1'b1;
      we_q         <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      access_n_q   <= access_n_d;
      we_q         <= we_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign bus.access_n   = access_n_q;
  assign bus.we         = we_q;
  assign bus.address    = address_q;
  assign bus.write_data = write_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sram_request_queue.sv
// Bench for sram_request_queue: a controller model with its own memory, an
// in-order reference model feeding expected queues, and negedge monitors.
module tb_sram_request_queue;
  import sram_pkg::*;

  localparam int DEPTH = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;
  logic [$clog2(DEPTH):0] dbg_count;

  always #5 clk = ~clk;

  sram_request_queue_if bus ();

  sram_request_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  int total = 0;
  int bad   = 0;
  int rsp_seen = 0;

  logic [64:0] iss_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] err_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] sram_mem[logic [31:0]];

  logic        ctrl_busy_n = 1'b1;
  logic        hold_low    = 1'b0;
  logic [31:0] ctrl_rdata  = '0;
  int          ctrl_lat    = 5;
  bit          rand_lat    = 1'b0;
  bit          ctrl_active = 1'b0;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wd;
  logic        prev_access_n = 1'b1;

  assign bus.busy_n    = ctrl_busy_n & ~hold_low;
  assign bus.read_data = ctrl_rdata;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [31:0] a);
    return sram_mem.exists(a) ? sram_mem[a] : 32'h0;
  endfunction

  // Reference: requests complete in acceptance order, so a read returns the
  // memory contents after all earlier accepted writes.
  task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d);
`ifdef SRAM_REQ_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) begin
      err_q.push_back(a);
      return;
    end
`endif
    iss_q.push_back({w, a, d});
    if (w) ref_mem[a] = d;
    else   exp_q.push_back(ref_rd(a));
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 300; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        model_accept(w, a, d);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (!ok) check("send_timeout", 65'd0, 65'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (iss_q.size() == 0 && exp_q.size() == 0 && err_q.size() == 0 &&
          !ctrl_active && dbg_state == S_IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 65'd0, 65'd1);
  endtask

  // Controller model: busy_n low for lat cycles, read_data valid as it rises.
  initial begin
    int lat;
    forever begin
      @(negedge clk);
      if (bus.access_n == 1'b0) begin
        c_we        = bus.we;
        c_addr      = bus.address;
        c_wd        = bus.write_data;
        ctrl_active = 1'b1;
        lat = rand_lat ? int'($urandom_range(1, 4)) : ctrl_lat;
        @(posedge clk);
        #1 ctrl_busy_n = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        if (c_we) begin
          sram_mem[c_addr] = c_wd;
          ctrl_rdata = $urandom;
        end else begin
          ctrl_rdata = sram_rd(c_addr);
        end
        ctrl_busy_n = 1'b1;
        ctrl_active = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [64:0] e_iss;
    logic [31:0] e_dat;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("count_le_depth", 65'(dbg_count <= DEPTH), 65'd1);
        if (!bus.access_n) begin
          check("access_single_cycle", 65'(prev_access_n), 65'd1);
          if (iss_q.size() == 0) begin
            check("unexpected_issue", {bus.we, bus.address, bus.write_data}, 65'h0_dead_0000_dead_0000);
          end else begin
            e_iss = iss_q.pop_front();
            check("issue", {bus.we, bus.address, bus.write_data}, e_iss);
          end
        end
        if (bus.rsp_valid) begin
          rsp_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 65'(bus.rsp_valid), 65'd0);
          end else begin
            e_dat = exp_q.pop_front();
            check("rsp_rdata", 65'(bus.rsp_rdata), 65'(e_dat));
          end
        end
        if (bus.req_err) begin
          if (err_q.size() == 0) check("unexpected_req_err", 65'(bus.req_err), 65'd0);
          else begin
            e_dat = err_q.pop_front();
            check("req_err", 65'(bus.req_err), 65'd1);
          end
        end
      end
      prev_access_n = bus.access_n;
    end
  end

  initial begin
    #400000;
    check("watchdog", 65'd0, 65'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int base;
    logic [31:0] a;
    bit ok;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_access_n",   65'(bus.access_n),   65'd1);
    check("rst_we",         65'(bus.we),         65'd0);
    check("rst_address",    65'(bus.address),    65'd0);
    check("rst_write_data", 65'(bus.write_data), 65'd0);
    check("rst_rsp_valid",  65'(bus.rsp_valid),  65'd0);
    check("rst_rsp_rdata",  65'(bus.rsp_rdata),  65'd0);
    check("rst_req_err",    65'(bus.req_err),    65'd0);
    check("rst_req_ready",  65'(bus.req_ready),  65'd1);
    check("rst_count",      65'(dbg_count),      65'd0);
    check("rst_state",      65'(dbg_state),      65'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Single posted write with a 5-cycle controller.
    ctrl_lat = 5;
    base = rsp_seen;
    send(1'b1, 32'h10, 32'hDEADBEEF);
    check("lat_before_issue", 65'(bus.access_n), 65'd1);
    @(negedge clk);
    check("lat_issue_cycle", 65'(bus.access_n), 65'd0);
    check("lat_issue_addr",  65'(bus.address),  65'h10);
    check("lat_issue_we",    65'(bus.we),       65'd1);
    drain();
    check("write_no_rsp", 65'(rsp_seen - base), 65'd0);

    // Write then read back.
    base = rsp_seen;
    send(1'b1, 32'h10, 32'hCAFEF00D);
    send(1'b0, 32'h10, 32'h0);
    drain();
    check("readback_rsp_count", 65'(rsp_seen - base), 65'd1);

    // Fill while the controller reports busy.
    hold_low = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(i[0], 32'h20 + 32'(i * 4), $urandom);
    check("full_ready_low", 65'(bus.req_ready), 65'd0);
    check("full_count",     65'(dbg_count),     65'(DEPTH));
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'h1234_5678;
    repeat (4) begin
      @(negedge clk);
      check("full_hold_ready", 65'(bus.req_ready), 65'd0);
      check("full_hold_no_issue", 65'(bus.access_n), 65'd1);
    end
    bus.req_valid = 1'b0;
    hold_low = 1'b0;
    send(1'b1, 32'h40, 32'h1234_5678);
    send(1'b0, 32'h40, 32'h0);
    drain();

    // Alternating writes and reads through pointer wrap, random latency.
    rand_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      send(i[0] == 1'b0, a, $urandom);
    end
    drain();
    for (int i = 0; i < 40; i++) begin
      a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
      send(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset while a read is in WAIT_DONE.
    rand_lat = 1'b0;
    ctrl_lat = 6;
    base = rsp_seen;
    send(1'b0, 32'h10, 32'h0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dbg_state == S_WAIT_DONE) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_wait_done", 65'(ok), 65'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_access_n",  65'(bus.access_n),  65'd1);
    check("mid_rst_count",     65'(dbg_count),     65'd0);
    check("mid_rst_req_ready", 65'(bus.req_ready), 65'd1);
    check("mid_rst_state",     65'(dbg_state),     65'(ST_IDLE));
    exp_q.delete();
    iss_q.delete();
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("aborted_read_no_rsp", 65'(rsp_seen - base), 65'd0);
    drain();

    // Misaligned read.
    ctrl_lat = 2;
    base = rsp_seen;
    send(1'b0, 32'h13, 32'h0);
    drain();
`ifdef SRAM_REQ_ALIGN_CHECK_EN
    check("misaligned_no_rsp", 65'(rsp_seen - base), 65'd0);
`else
    check("misaligned_issued_rsp", 65'(rsp_seen - base), 65'd1);
`endif

    check("end_iss_q_empty", 65'(iss_q.size()), 65'd0);
    check("end_exp_q_empty", 65'(exp_q.size()), 65'd0);
    check("end_err_q_empty", 65'(err_q.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
